// File: rtl/uart_tx_vo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_vo
// Brief    : UART transmitter with a runtime-variable bit period. Bytes written
//            on in/clk_in are queued in a small FIFO and sent as 8N1 or 8N2
//            frames on out. The bit period is taken from o (0 behaves as 1) and
//            is latched once per frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_vo #(
    parameter int OW   = 4,
    parameter int FD   = 2,
    parameter int STOP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in,
    input  logic          clk_in,
    input  logic [OW-1:0] o,
    output logic          out,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic          ovf
);

    localparam int         c_DEPTH    = 1 << FD;
    localparam logic [FD:0] c_FULL_CNT = {1'b1, {FD{1'b0}}};
    localparam logic [2:0]  c_LAST_STOP = 3'(STOP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state_q, r_state_d;
    logic [7:0]    r_sr_q,    r_sr_d;
    logic [OW-1:0] r_per_q,   r_per_d;
    logic [OW-1:0] r_cnt_q,   r_cnt_d;
    logic [2:0]    r_idx_q,   r_idx_d;
    logic          r_out_q,   r_out_d;
    logic          r_busy_q,  r_busy_d;
    logic [FD-1:0] r_wptr_q,  r_wptr_d;
    logic [FD-1:0] r_rptr_q,  r_rptr_d;
    logic [FD:0]   r_count_q, r_count_d;
    logic          r_full_q,  r_full_d;
    logic          r_empty_q, r_empty_d;
    logic          r_ovf_q,   r_ovf_d;

    logic [7:0]    r_mem [c_DEPTH];

    logic          w_wr_en;
    logic          w_pop;
    logic          w_bit_end;
    logic [OW-1:0] w_per_new;

    // Write is accepted only when the FIFO is not full; a zero period behaves as one.
    assign w_wr_en   = clk_in & ~r_full_q;
    assign w_per_new = (o == '0) ? OW'(1) : o;
    assign w_bit_end = (r_cnt_q == (r_per_q - OW'(1)));

    // Next-state logic for the frame FSM and the FIFO bookkeeping.
    always_comb begin
        r_state_d = r_state_q;
        r_sr_d    = r_sr_q;
        r_per_d   = r_per_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        r_out_d   = r_out_q;
        r_busy_d  = r_busy_q;
        w_pop     = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                r_out_d  = 1'b1;
                r_busy_d = 1'b0;
                if (!r_empty_q) begin
                    w_pop     = 1'b1;
                    r_sr_d    = r_mem[r_rptr_q];
                    r_per_d   = w_per_new;
                    r_cnt_d   = '0;
                    r_idx_d   = '0;
                    r_out_d   = 1'b0;
                    r_busy_d  = 1'b1;
                    r_state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    r_cnt_d   = '0;
                    r_idx_d   = '0;
                    r_out_d   = r_sr_q[0];
                    r_state_d = S_DATA;
                end else begin
                    r_cnt_d = r_cnt_q + OW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    r_cnt_d = '0;
                    if (r_idx_q == 3'd7) begin
                        r_idx_d   = '0;
                        r_out_d   = 1'b1;
                        r_state_d = S_STOP;
                    end else begin
                        // Next bit is sr[1] because the shift lands on this same edge.
                        r_sr_d  = {1'b0, r_sr_q[7:1]};
                        r_out_d = r_sr_q[1];
                        r_idx_d = r_idx_q + 3'd1;
                    end
                end else begin
                    r_cnt_d = r_cnt_q + OW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    r_cnt_d = '0;
                    if (r_idx_q == c_LAST_STOP) begin
                        r_idx_d = '0;
                        if (!r_empty_q) begin
                            // Chain straight into the next start bit, no idle gap.
                            w_pop     = 1'b1;
                            r_sr_d    = r_mem[r_rptr_q];
                            r_per_d   = w_per_new;
                            r_out_d   = 1'b0;
                            r_busy_d  = 1'b1;
                            r_state_d = S_START;
                        end else begin
                            r_out_d   = 1'b1;
                            r_busy_d  = 1'b0;
                            r_state_d = S_IDLE;
                        end
                    end else begin
                        r_idx_d = r_idx_q + 3'd1;
                    end
                end else begin
                    r_cnt_d = r_cnt_q + OW'(1);
                end
            end
            default: begin
                r_out_d   = 1'b1;
                r_busy_d  = 1'b0;
                r_state_d = S_IDLE;
            end
        endcase

        r_wptr_d  = w_wr_en ? (r_wptr_q + FD'(1)) : r_wptr_q;
        r_rptr_d  = w_pop   ? (r_rptr_q + FD'(1)) : r_rptr_q;
        r_count_d = r_count_q;
        case ({w_wr_en, w_pop})
            2'b10:   r_count_d = r_count_q + 1'b1;
            2'b01:   r_count_d = r_count_q - 1'b1;
            default: r_count_d = r_count_q;
        endcase
        r_full_d  = (r_count_d == c_FULL_CNT);
        r_empty_d = (r_count_d == '0);
        r_ovf_d   = clk_in & r_full_q;
    end

    // State registers; reset abandons any frame and forces the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_sr_q    <= '0;
            r_per_q   <= OW'(1);
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_out_q   <= 1'b1;
            r_busy_q  <= 1'b0;
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
            r_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_sr_q    <= r_sr_d;
            r_per_q   <= r_per_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_out_q   <= r_out_d;
            r_busy_q  <= r_busy_d;
            r_wptr_q  <= r_wptr_d;
            r_rptr_q  <= r_rptr_d;
            r_count_q <= r_count_d;
            r_full_q  <= r_full_d;
            r_empty_q <= r_empty_d;
            r_ovf_q   <= r_ovf_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr_q] <= in;
        end
    end

    assign out   = r_out_q;
    assign busy  = r_busy_q;
    assign full  = r_full_q;
    assign empty = r_empty_q;
    assign ovf   = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_vo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_vo
// Brief    : Scoreboard bench for uart_tx_vo. Writers push the expected frame
//            (byte, bit period, back-to-back flag); a monitor decodes the line
//            and compares each frame cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_vo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       wr  = 1'b0;
    logic       wr2 = 1'b0;
    logic [3:0] o   = 4'd5;

    logic out1, busy1, full1, empty1, ovf1;
    logic out2, busy2, full2, empty2, ovf2;

    always #5 clk = ~clk;

    uart_tx_vo #(.OW(4), .FD(2), .STOP(1)) u_dut (
        .clk(clk), .rst(rst), .in(din), .clk_in(wr), .o(o),
        .out(out1), .busy(busy1), .full(full1), .empty(empty1), .ovf(ovf1)
    );

    uart_tx_vo #(.OW(4), .FD(2), .STOP(2)) u_dut2 (
        .clk(clk), .rst(rst), .in(din), .clk_in(wr2), .o(o),
        .out(out2), .busy(busy2), .full(full2), .empty(empty2), .ovf(ovf2)
    );

    typedef struct {
        logic [7:0] data;
        int         p;
        bit         b2b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [7:0] d, input int p, input bit b);
        exp_t e;
        e.data = d;
        e.p    = p;
        e.b2b  = b;
        sb.push_back(e);
    endtask

    task automatic wr_start(input logic [7:0] d);
        @(negedge clk);
        din = d;
        wr  = 1'b1;
    endtask

    task automatic wr_stop();
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Decode one frame; the current negedge is its first start-bit cycle.
    task automatic run_frame(output bit chained);
        exp_t       e;
        int         errs;
        int         b;
        logic [7:0] got;
        logic       eb;
        chained = 1'b0;
        if (sb.size() == 0) begin
            check("idle_line", 64'(out1), 64'(1));
            return;
        end
        e    = sb.pop_front();
        errs = 0;
        got  = 8'h00;
        for (int c = 0; c < 10 * e.p; c++) begin
            if (c > 0) @(negedge clk);
            b  = c / e.p;
            eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
            if (out1 !== eb || busy1 !== 1'b1) errs++;
            if (b >= 1 && b <= 8 && (c % e.p) == 0) got[b-1] = out1;
        end
        check("frame_shape", 64'(errs), 64'(0));
        check("frame_data", 64'(got), 64'(e.data));
        @(negedge clk);
        if (sb.size() > 0 && sb[0].b2b) begin
            check("b2b_start", 64'(out1), 64'(0));
            chained = (out1 === 1'b0);
        end else begin
            check("busy_drop", 64'({busy1, out1}), 64'(2'b01));
        end
    endtask

    // Monitor: watches the line and decodes frames against the scoreboard.
    initial begin
        bit ch;
        forever begin
            @(negedge clk);
            if (mon_en && out1 === 1'b0) begin
                mon_busy = 1'b1;
                run_frame(ch);
                while (ch) run_frame(ch);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || mon_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", 64'(sb.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int         lows;
        int         t;
        logic [7:0] bv;
        logic [39:0] s_out, s_busy, e_out, e_busy;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out",   64'(out1),   64'(1));
        check("rst_busy",  64'(busy1),  64'(0));
        check("rst_full",  64'(full1),  64'(0));
        check("rst_empty", 64'(empty1), 64'(1));
        check("rst_ovf",   64'(ovf1),   64'(0));
        rst = 1'b0;

        // Reset in the middle of data bit 3
        o = 4'd5;
        wr_start(8'hA5);
        wr_stop();
        repeat (23) @(posedge clk);
        #2;
        check("busy_mid_frame", 64'(busy1), 64'(1));
        rst = 1'b1;
        #1;
        check("async_rst_out",   64'(out1),   64'(1));
        check("async_rst_busy",  64'(busy1),  64'(0));
        check("async_rst_empty", 64'(empty1), 64'(1));
        @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (out1 !== 1'b1 || busy1 !== 1'b0) lows++;
        end
        check("line_high_after_rst", 64'(lows), 64'(0));
        mon_en = 1'b1;

        // Single byte, period 5
        o = 4'd5;
        push(8'hA5, 5, 1'b0);
        wr_start(8'hA5);
        wr_stop();
        drain();

        // Back-to-back, period 4
        o = 4'd4;
        push(8'h00, 4, 1'b0);
        push(8'hFF, 4, 1'b1);
        wr_start(8'h00);
        wr_start(8'hFF);
        wr_stop();
        drain();

        // Period changed during frame 1 applies only to frame 2
        o = 4'd5;
        push(8'h5A, 5, 1'b0);
        push(8'h3C, 8, 1'b1);
        wr_start(8'h5A);
        wr_start(8'h3C);
        wr_stop();
        repeat (15) @(negedge clk);
        o = 4'd8;
        drain();

        // Overflow: six writes in six cycles, the sixth dropped
        o = 4'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) check("full_set", 64'(full1), 64'(1));
            bv  = 8'(17 * (i + 1));
            din = bv;
            wr  = 1'b1;
            if (i < 5) push(bv, 2, (i > 0));
        end
        @(negedge clk);
        check("ovf_pulse", 64'(ovf1), 64'(1));
        wr = 1'b0;
        @(negedge clk);
        check("ovf_clear", 64'(ovf1), 64'(0));
        drain();
        check("empty_after_burst", 64'(empty1), 64'(1));

        // Edge periods: 0 acts as 1, 15 is the maximum
        o = 4'd0;
        push(8'hC6, 1, 1'b0);
        wr_start(8'hC6);
        wr_stop();
        drain();
        o = 4'd15;
        push(8'h81, 15, 1'b0);
        wr_start(8'h81);
        wr_stop();
        drain();

        // Two stop bits at period 3 on the second instance
        o = 4'd3;
        @(negedge clk);
        din = 8'hC3;
        wr2 = 1'b1;
        @(negedge clk);
        wr2 = 1'b0;
        t = 0;
        while (out2 !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        bv = 8'hC3;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            s_out[c]  = out2;
            s_busy[c] = busy2;
            e_busy[c] = (c < 33);
            if (c < 3)       e_out[c] = 1'b0;
            else if (c < 27) e_out[c] = bv[(c / 3) - 1];
            else             e_out[c] = 1'b1;
        end
        check("stop2_line", 64'(s_out),  64'(e_out));
        check("stop2_busy", 64'(s_busy), 64'(e_busy));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
